instr_mem: RTL and testbench

//  Instruction-memory responder for the 16-bit processor's fetch port.
//  - Processor drives fetch_addr/fetch_req; this block returns the stored

---
 rtl/proc_pkg.sv | 11 +
 rtl/instr_ram_1r1w.sv | 31 +++
 rtl/instr_mem.sv | 75 +++++++
 tb/tb_instr_mem.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, opcodes and instruction-memory FSM states for the 16-bit processor
package proc_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'hF;
  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};
  typedef enum logic {CLEAR, RUN} mem_state_e;
endpackage

// File: rtl/instr_ram_1r1w.sv
// instr_ram_1r1w: DEPTH x DATA_W storage, synchronous write, registered read
// Ports: clk_i, rst_ni (async, resets only the read register), we_i/waddr_i/wdata_i write port,
//        re_i/raddr_i read request, rdata_o registered read data (holds when re_i low)
module instr_ram_1r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // unimplemented addresses read back as zero
  always_comb rdata_d = ({1'b0, raddr_i} < LIMIT) ? mem_q[raddr_i] : '0;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= rdata_d;
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_mem.sv
// instr_mem: instruction-memory responder; clears to NOP after reset, then serves fetches and loads
// Ports: clk, rst_n (async active-low); fetch_req/fetch_addr -> instr_valid/instruction one cycle later;
//        load_valid/load_ready/load_addr/load_data load handshake; busy during clear sweep;
//        load_err sticky flag for dropped out-of-range loads
module instr_mem
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              load_err
);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  mem_state_e        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              clearing, load_fire, load_ok, ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  // fetch has priority over load; the sweep owns the write port while clearing
  always_comb begin
    clearing   = state_q == CLEAR;
    load_ready = ~clearing & ~fetch_req;
    load_fire  = load_valid & load_ready;
    load_ok    = {1'b0, load_addr} < LIMIT;
    ram_we     = clearing | (load_fire & load_ok);
    ram_waddr  = clearing ? cnt_q[ADDR_W-1:0] : load_addr;
    ram_wdata  = clearing ? DATA_W'(NOP_WORD) : load_data;
    ram_re     = ~clearing & fetch_req;
    valid_d    = ram_re;
    cnt_d      = clearing ? cnt_q + 1'b1 : cnt_q;
    state_d    = (clearing && cnt_q == LAST) ? RUN : state_q;
    err_d      = err_q | (load_fire & ~load_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  instr_ram_1r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(fetch_addr),
    .rdata_o(instruction)
  );
  assign instr_valid = valid_q;
  assign busy        = clearing;
  assign load_err    = err_q;
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed self-checking bench for instr_mem at DEPTH=8 and DEPTH=6
module tb_instr_mem;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetch_req = 1'b0, load_valid = 1'b0;
  logic [2:0] fetch_addr = '0, load_addr = '0;
  logic [15:0] load_data = '0;
  logic v8, lr8, b8, e8, v6, lr6, b6, e6;
  logic [15:0] i8, i6;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  instr_mem #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_valid(v8), .instruction(i8), .load_valid(load_valid), .load_ready(lr8),
    .load_addr(load_addr), .load_data(load_data), .busy(b8), .load_err(e8));
  instr_mem #(.DATA_W(16), .ADDR_W(3), .DEPTH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_valid(v6), .instruction(i6), .load_valid(load_valid), .load_ready(lr6),
    .load_addr(load_addr), .load_data(load_data), .busy(b6), .load_err(e6));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (v8 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", v8); end
    checks++; if (i8 !== 16'h0000) begin fails++; $display("FAIL reset_instr: got %h want 0000", i8); end
    checks++; if (b8 !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", b8); end
    checks++; if (e8 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", e8); end
    checks++; if (lr8 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", lr8); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch_req = i[0]; fetch_addr = 3'd1;
      load_valid = 1'b1; load_addr = 3'd1; load_data = 16'hFFFF;
      #1;
      checks++; if (b8 !== 1'b1) begin fails++; $display("FAIL sweep_busy[%0d]: got %b want 1", i, b8); end
      checks++; if (lr8 !== 1'b0) begin fails++; $display("FAIL sweep_ready[%0d]: got %b want 0", i, lr8); end
      checks++; if (v8 !== 1'b0) begin fails++; $display("FAIL sweep_valid[%0d]: got %b want 0", i, v8); end
      step();
    end
    fetch_req = 1'b0; load_valid = 1'b0;
    #1;
    checks++; if (b8 !== 1'b0) begin fails++; $display("FAIL sweep_done_busy: got %b want 0", b8); end
    checks++; if (v8 !== 1'b0) begin fails++; $display("FAIL sweep_done_valid: got %b want 0", v8); end
    checks++; if (lr8 !== 1'b1) begin fails++; $display("FAIL run_ready: got %b want 1", lr8); end
    for (int i = 0; i < 8; i++) begin
      fetch_req = 1'b1; fetch_addr = 3'(i);
      step();
      checks++; if (v8 !== 1'b1) begin fails++; $display("FAIL clr_valid[%0d]: got %b want 1", i, v8); end
      checks++; if (i8 !== 16'h0000) begin fails++; $display("FAIL clr_data[%0d]: got %h want 0000", i, i8); end
    end
    fetch_req = 1'b0;
    step();
  endtask
  task automatic test_load_fetch();
    load_valid = 1'b1; load_addr = 3'd2; load_data = 16'h1205;
    #1;
    checks++; if (lr8 !== 1'b1) begin fails++; $display("FAIL load_ready: got %b want 1", lr8); end
    step();
    load_addr = 3'd3; load_data = 16'h2440;
    step();
    load_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 3'd2;
    step();
    checks++; if (v8 !== 1'b1 || i8 !== 16'h1205) begin fails++; $display("FAIL b2b_first: got %b/%h want 1/1205", v8, i8); end
    fetch_addr = 3'd3;
    step();
    checks++; if (v8 !== 1'b1 || i8 !== 16'h2440) begin fails++; $display("FAIL b2b_second: got %b/%h want 1/2440", v8, i8); end
    fetch_req = 1'b0;
    step();
    checks++; if (v8 !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", v8); end
    checks++; if (i8 !== 16'h2440) begin fails++; $display("FAIL idle_hold: got %h want 2440", i8); end
  endtask
  task automatic test_priority();
    fetch_req = 1'b1; fetch_addr = 3'd5;
    load_valid = 1'b1; load_addr = 3'd5; load_data = 16'hABCD;
    #1;
    checks++; if (lr8 !== 1'b0) begin fails++; $display("FAIL prio_ready: got %b want 0", lr8); end
    step();
    step();
    checks++; if (v8 !== 1'b1 || i8 !== 16'h0000) begin fails++; $display("FAIL prio_nowrite: got %b/%h want 1/0000", v8, i8); end
    fetch_req = 1'b0;
    #1;
    checks++; if (lr8 !== 1'b1) begin fails++; $display("FAIL prio_release: got %b want 1", lr8); end
    step();
    load_valid = 1'b0; fetch_req = 1'b1;
    step();
    checks++; if (v8 !== 1'b1 || i8 !== 16'hABCD) begin fails++; $display("FAIL raw_data: got %b/%h want 1/abcd", v8, i8); end
    fetch_req = 1'b0;
    step();
  endtask
  task automatic test_out_of_range();
    checks++; if (e6 !== 1'b0) begin fails++; $display("FAIL oob_err_pre: got %b want 0", e6); end
    load_valid = 1'b1; load_addr = 3'd7; load_data = 16'hBEEF;
    #1;
    checks++; if (lr6 !== 1'b1) begin fails++; $display("FAIL oob_ready: got %b want 1", lr6); end
    step();
    load_valid = 1'b0;
    checks++; if (e6 !== 1'b1) begin fails++; $display("FAIL oob_err_set: got %b want 1", e6); end
    checks++; if (e8 !== 1'b0) begin fails++; $display("FAIL inrange_err: got %b want 0", e8); end
    repeat (3) step();
    checks++; if (e6 !== 1'b1) begin fails++; $display("FAIL oob_err_sticky: got %b want 1", e6); end
    fetch_req = 1'b1; fetch_addr = 3'd7;
    step();
    checks++; if (v6 !== 1'b1 || i6 !== 16'h0000) begin fails++; $display("FAIL oob_fetch: got %b/%h want 1/0000", v6, i6); end
    checks++; if (v8 !== 1'b1 || i8 !== 16'hBEEF) begin fails++; $display("FAIL d8_addr7: got %b/%h want 1/beef", v8, i8); end
    fetch_req = 1'b0;
    step();
  endtask
  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 3'd2;
    step();
    checks++; if (v8 !== 1'b1 || i8 !== 16'h1205) begin fails++; $display("FAIL pre_rst_fetch: got %b/%h want 1/1205", v8, i8); end
    fetch_req = 1'b0;
    load_valid = 1'b1; load_addr = 3'd4; load_data = 16'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (v8 !== 1'b0) begin fails++; $display("FAIL async_valid: got %b want 0", v8); end
    checks++; if (i8 !== 16'h0000) begin fails++; $display("FAIL async_instr: got %h want 0000", i8); end
    checks++; if (e6 !== 1'b0) begin fails++; $display("FAIL async_err: got %b want 0", e6); end
    checks++; if (b8 !== 1'b1 || lr8 !== 1'b0) begin fails++; $display("FAIL async_busy_ready: got %b/%b want 1/0", b8, lr8); end
    step();
    load_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (b8 !== 1'b1) begin fails++; $display("FAIL resweep_busy[%0d]: got %b want 1", i, b8); end
      step();
    end
    checks++; if (b8 !== 1'b0) begin fails++; $display("FAIL resweep_done: got %b want 0", b8); end
    for (int i = 2; i < 6; i++) begin
      fetch_req = 1'b1; fetch_addr = 3'(i);
      step();
      checks++; if (v8 !== 1'b1 || i8 !== 16'h0000) begin fails++; $display("FAIL recleared[%0d]: got %b/%h want 1/0000", i, v8, i8); end
    end
    fetch_req = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    test_load_fetch();
    test_priority();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
